// File: rtl/bg_pkg.sv
// Shared constants and types for the background scroll datapath.
// Exports BG_W/BG_H, accumulator width, speed defaults and scroll_state_t.
// No logic; imported by bg_scroll_ctrl and friends.
package bg_pkg;
  localparam int BG_W        = 320;  // background width in ROM pixels
  localparam int BG_H        = 240;  // background height in ROM pixels
  localparam int ACC_W       = 13;   // 9.4 fixed-point scroll accumulator
  localparam int SPD_INIT    = 16;   // 1.0 px/frame in 4.4
  localparam int SPD_MAX     = 64;   // 4.0 px/frame in 4.4
  localparam int RAMP_FRAMES = 256;  // RUN frames per +1/16 px speed step
  localparam int SHAKE_TICKS = 16;   // frames of vertical shake after a crash

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DEAD = 2'd3
  } scroll_state_t;
endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: pulse is high for one cycle, one cycle after din rises.
// Ports: clk, rst (sync, active-high), din (level), pulse (one-cycle output).
// din_q resets high so a level that is already high at reset release is not an edge.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b1;
      pulse <= 1'b0;
    end else begin
      din_q <= din;
      pulse <= din & ~din_q;
    end
  end
endmodule

// File: rtl/bg_scroll_ctrl.sv
// Frame-synchronous scroll controller: game-phase FSM plus a 9.4 fixed-point horizontal
// scroll accumulator advanced once per frame (vblnk rising edge), with a speed ramp in RUN.
// Ports: clk, rst (sync, active-high), vblnk, start/crash (pulses), pause (level),
//        scroll_x (0..BG_W-1), scroll_y (signed shake), frame_tick, state (scroll_state_t).
// Optional: define SCROLL_SHAKE_EN for a 16-frame +2/-2 vertical shake on entry to DEAD.
module bg_scroll_ctrl #(
  parameter int BG_W        = bg_pkg::BG_W,
  parameter int SPD_INIT    = bg_pkg::SPD_INIT,
  parameter int SPD_MAX     = bg_pkg::SPD_MAX,
  parameter int RAMP_FRAMES = bg_pkg::RAMP_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       pause,
  input  logic       crash,
  output logic [8:0] scroll_x,
  output logic [2:0] scroll_y,
  output logic       frame_tick,
  output logic [1:0] state
);
  import bg_pkg::*;

  localparam int RW   = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam int WRAP = BG_W * 16;

  scroll_state_t       st;
  logic [ACC_W-1:0]    acc;
  logic [6:0]          speed;
  logic [RW-1:0]       ramp_cnt;

  logic [6:0]          step;
  logic                advance;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_next;

  edge_rise u_vblnk_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (vblnk),
    .pulse (frame_tick)
  );

  // Step for the coming tick. RUN with pause high already counts as frozen, even
  // though the FSM only moves to HALT on the following cycle.
  always_comb begin
    step    = '0;
    advance = 1'b0;
    case (st)
      IDLE: step = 7'(SPD_INIT);
      RUN: begin
        if (!pause) begin
          step    = speed;
          advance = 1'b1;
        end
      end
      default: step = '0;
    endcase
    sum = {1'b0, acc} + (ACC_W+1)'(step);
    // step never exceeds one image width, so one subtraction keeps acc in range
    if (sum >= (ACC_W+1)'(WRAP))
      acc_next = ACC_W'(sum - (ACC_W+1)'(WRAP));
    else
      acc_next = ACC_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      acc      <= '0;
      speed    <= 7'(SPD_INIT);
      ramp_cnt <= '0;
    end else begin
      if (frame_tick) begin
        acc <= acc_next;
        if (advance) begin
          if (ramp_cnt == RW'(RAMP_FRAMES - 1)) begin
            ramp_cnt <= '0;
            if (speed < 7'(SPD_MAX))
              speed <= speed + 7'd1;
          end else begin
            ramp_cnt <= ramp_cnt + RW'(1);
          end
        end
      end

      // Events are taken every cycle; a (re)start overrides any same-cycle ramp update.
      // acc is never touched here, so a restart from DEAD continues without a jump.
      case (st)
        IDLE: begin
          if (start) begin
            st       <= RUN;
            speed    <= 7'(SPD_INIT);
            ramp_cnt <= '0;
          end
        end
        RUN: begin
          if (crash)
            st <= DEAD;
          else if (start) begin
            speed    <= 7'(SPD_INIT);
            ramp_cnt <= '0;
          end else if (pause)
            st <= HALT;
        end
        HALT: begin
          if (crash)
            st <= DEAD;
          else if (start) begin
            st       <= RUN;
            speed    <= 7'(SPD_INIT);
            ramp_cnt <= '0;
          end else if (!pause)
            st <= RUN;
        end
        DEAD: begin
          if (start) begin
            st       <= RUN;
            speed    <= 7'(SPD_INIT);
            ramp_cnt <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign scroll_x = acc[ACC_W-1:4];
  assign state    = st;

`ifdef SCROLL_SHAKE_EN
  logic [4:0] shake_cnt;
  logic [2:0] shake_y;

  // Counts down one per tick; even counts give +2 and odd give -2, so the
  // sequence starts at +2 and alternates for SHAKE_TICKS ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      shake_cnt <= '0;
      shake_y   <= '0;
    end else if ((st == RUN || st == HALT) && crash) begin
      shake_cnt <= 5'(SHAKE_TICKS);
      shake_y   <= '0;
    end else if (st == DEAD && start) begin
      shake_cnt <= '0;
      shake_y   <= '0;
    end else if (frame_tick) begin
      if (shake_cnt != '0) begin
        shake_y   <= shake_cnt[0] ? 3'b110 : 3'b010;
        shake_cnt <= shake_cnt - 5'd1;
      end else begin
        shake_y <= '0;
      end
    end
  end

  assign scroll_y = shake_y;
`else
  assign scroll_y = '0;
`endif
endmodule

// File: tb/tb_bg_scroll_ctrl.sv
module tb_bg_scroll_ctrl;
  logic       clk;
  logic       rst;
  logic       vblnk;
  logic       start;
  logic       pause;
  logic       crash;
  logic [8:0] scroll_x;
  logic [2:0] scroll_y;
  logic       frame_tick;
  logic [1:0] state;

  int n_tests;
  int n_fail;

  bg_scroll_ctrl #(
    .BG_W        (320),
    .SPD_INIT    (16),
    .SPD_MAX     (64),
    .RAMP_FRAMES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .start      (start),
    .pause      (pause),
    .crash      (crash),
    .scroll_x   (scroll_x),
    .scroll_y   (scroll_y),
    .frame_tick (frame_tick),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_frame(output int ticks);
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      vblnk = (i < 3);
      @(negedge clk);
      if (frame_tick) ticks++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; vblnk = 1'b0; start = 1'b0; pause = 1'b0; crash = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic c);
    start = s; crash = c;
    @(negedge clk);
    start = 1'b0; crash = 1'b0;
  endtask

  task automatic test_reset();
    int t;
    int ticks;
    apply_reset();
    n_tests++;
    if (scroll_x !== 9'd0 || scroll_y !== 3'd0 || state !== 2'd0 || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: x=%0d y=%0d st=%0d ft=%0b want 0 0 0 0",
               scroll_x, scroll_y, state, frame_tick);
    end
    do_frame(t);
    do_frame(t);
    // reset in the middle of a frame with vblnk high, released while still high
    vblnk = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (scroll_x !== 9'd0 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: x=%0d st=%0d want 0 0", scroll_x, state);
    end
    @(negedge clk);
    rst = 1'b0;
    ticks = 0;
    repeat (4) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    n_tests++;
    if (ticks !== 0 || scroll_x !== 9'd0) begin
      n_fail++;
      $display("FAIL no_tick_at_release: ticks=%0d x=%0d want 0 0", ticks, scroll_x);
    end
    vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_scroll();
    int t;
    apply_reset();
    for (int f = 1; f <= 3; f++) begin
      do_frame(t);
      n_tests++;
      if (t !== 1 || scroll_x !== 9'(f)) begin
        n_fail++;
        $display("FAIL idle_frame%0d: ticks=%0d x=%0d want 1 %0d", f, t, scroll_x, f);
      end
    end
    pulse(1'b0, 1'b1);
    n_tests++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_crash_ignored: st=%0d want 0", state);
    end
  endtask

  task automatic test_back_to_back();
    int ticks;
    apply_reset();
    ticks = 0;
    for (int i = 0; i < 9; i++) begin
      vblnk = (i < 8) ? ((i % 2) == 0) : 1'b0;
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    @(negedge clk);
    n_tests++;
    if (ticks !== 4 || scroll_x !== 9'd4) begin
      n_fail++;
      $display("FAIL back_to_back: ticks=%0d x=%0d want 4 4", ticks, scroll_x);
    end
  endtask

  task automatic test_ramp();
    int t;
    logic [8:0] exp_x [20];
    // speed 16 for frames 1-4, 17 for 5-8, 18 for 9-12, 19 for 13-16, 20 for 17-20
    exp_x = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8, 9'd9, 9'd10,
              9'd11, 9'd12, 9'd13, 9'd15, 9'd16, 9'd17, 9'd18, 9'd20, 9'd21, 9'd22};
    apply_reset();
    pulse(1'b1, 1'b0);
    n_tests++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_to_run: st=%0d want 1", state);
    end
    for (int f = 0; f < 20; f++) begin
      do_frame(t);
      n_tests++;
      if (scroll_x !== exp_x[f]) begin
        n_fail++;
        $display("FAIL ramp_frame%0d: x=%0d want %0d", f + 1, scroll_x, exp_x[f]);
      end
    end
  endtask

  task automatic test_wrap();
    int t;
    apply_reset();
    for (int f = 1; f <= 322; f++) begin
      do_frame(t);
      n_tests++;
      if (scroll_x !== 9'(f % 320)) begin
        n_fail++;
        $display("FAIL wrap_frame%0d: x=%0d want %0d", f, scroll_x, f % 320);
      end
    end
  endtask

  task automatic test_pause();
    int t;
    logic [8:0] exp_resume [3];
    exp_resume = '{9'd3, 9'd4, 9'd5};
    apply_reset();
    pulse(1'b1, 1'b0);
    do_frame(t);
    do_frame(t);
    pause = 1'b1;
    @(negedge clk);
    n_tests++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL pause_to_halt: st=%0d want 2", state);
    end
    for (int f = 0; f < 5; f++) begin
      do_frame(t);
      n_tests++;
      if (scroll_x !== 9'd2 || state !== 2'd2) begin
        n_fail++;
        $display("FAIL halt_frozen%0d: x=%0d st=%0d want 2 2", f, scroll_x, state);
      end
    end
    pause = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL unpause_to_run: st=%0d want 1", state);
    end
    for (int f = 0; f < 3; f++) begin
      do_frame(t);
      n_tests++;
      if (scroll_x !== exp_resume[f]) begin
        n_fail++;
        $display("FAIL resume_frame%0d: x=%0d want %0d", f, scroll_x, exp_resume[f]);
      end
    end
  endtask

  task automatic test_crash_restart();
    int t;
    apply_reset();
    pulse(1'b1, 1'b0);
    repeat (12) do_frame(t);
    n_tests++;
    if (scroll_x !== 9'd12) begin
      n_fail++;
      $display("FAIL pre_crash: x=%0d want 12", scroll_x);
    end
    pulse(1'b1, 1'b1);
    n_tests++;
    if (state !== 2'd3) begin
      n_fail++;
      $display("FAIL crash_beats_start: st=%0d want 3", state);
    end
`ifdef SCROLL_SHAKE_EN
    for (int f = 0; f < 17; f++) begin
      logic [2:0] want_y;
      want_y = (f == 16) ? 3'b000 : (((f % 2) == 0) ? 3'b010 : 3'b110);
      do_frame(t);
      n_tests++;
      if (scroll_y !== want_y || scroll_x !== 9'd12) begin
        n_fail++;
        $display("FAIL shake_frame%0d: y=%b x=%0d want %b 12", f, scroll_y, scroll_x, want_y);
      end
    end
`else
    for (int f = 0; f < 2; f++) begin
      do_frame(t);
      n_tests++;
      if (scroll_y !== 3'd0 || scroll_x !== 9'd12) begin
        n_fail++;
        $display("FAIL dead_frozen%0d: y=%0d x=%0d want 0 12", f, scroll_y, scroll_x);
      end
    end
`endif
    pulse(1'b1, 1'b0);
    n_tests++;
    if (state !== 2'd1) begin
      n_fail++;
      $display("FAIL restart_to_run: st=%0d want 1", state);
    end
    do_frame(t);
    n_tests++;
    if (scroll_x !== 9'd13) begin
      n_fail++;
      $display("FAIL restart_continuous: x=%0d want 13", scroll_x);
    end
    repeat (3) do_frame(t);
    n_tests++;
    if (scroll_x !== 9'd16) begin
      n_fail++;
      $display("FAIL restart_speed_init: x=%0d want 16", scroll_x);
    end
`ifdef SCROLL_SHAKE_EN
    pulse(1'b0, 1'b1);
    do_frame(t);
    n_tests++;
    if (scroll_y !== 3'b010) begin
      n_fail++;
      $display("FAIL shake_first: y=%b want 010", scroll_y);
    end
    pulse(1'b1, 1'b0);
    n_tests++;
    if (scroll_y !== 3'b000) begin
      n_fail++;
      $display("FAIL shake_abort: y=%b want 000", scroll_y);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; vblnk = 1'b0; start = 1'b0; pause = 1'b0; crash = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle_scroll();
    test_back_to_back();
    test_ramp();
    test_wrap();
    test_pause();
    test_crash_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
